// File: rtl/class_argmax_seq.sv
// Sequential argmax: snapshots CLASS_NUM signed sums on the adder_done rise, scans one class
// per cycle and holds the winner under valid/ready. Optional runner-up: ARGMAX_RUNNER_UP_EN.
module class_argmax_seq #(
  parameter int CLASS_NUM     = 10,
  parameter int WEIGHT_LENGTH = 12,
  localparam int IDX_W        = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [CLASS_NUM-1:0][WEIGHT_LENGTH-1:0]  class_sums,
  input  logic                                     adder_done,
  input  logic                                     out_ready,
  output logic                                     out_valid,
  output logic [IDX_W-1:0]                         pred_class,
  output logic signed [WEIGHT_LENGTH-1:0]          pred_score,
  output logic                                     busy,
  output logic                                     overrun
`ifdef ARGMAX_RUNNER_UP_EN
  ,
  output logic [IDX_W-1:0]                         runner_class,
  output logic [WEIGHT_LENGTH:0]                   margin
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, RESULT} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CLASS_NUM - 1);
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);

  state_t                          state;
  logic                            done_q;
  logic                            start;
  logic signed [WEIGHT_LENGTH-1:0] snap [CLASS_NUM];
  logic signed [WEIGHT_LENGTH-1:0] best;
  logic signed [WEIGHT_LENGTH-1:0] cand;
  logic signed [WEIGHT_LENGTH-1:0] next_best;
  logic [IDX_W-1:0]                idx;
  logic [IDX_W-1:0]                best_idx;
  logic [IDX_W-1:0]                next_best_idx;
  logic                            take;

  assign start         = adder_done & ~done_q;
  assign cand          = snap[idx];
  // Strict compare so ties keep the lower index.
  assign take          = cand > best;
  assign next_best     = take ? cand : best;
  assign next_best_idx = take ? idx : best_idx;

`ifdef ARGMAX_RUNNER_UP_EN
  logic signed [WEIGHT_LENGTH-1:0] second;
  logic signed [WEIGHT_LENGTH-1:0] next_second;
  logic [IDX_W-1:0]                second_idx;
  logic [IDX_W-1:0]                next_second_idx;
  logic [WEIGHT_LENGTH:0]          next_margin;

  // At the first compare the loser of classes 0/1 seeds the runner-up.
  always_comb begin
    next_second     = second;
    next_second_idx = second_idx;
    if (take) begin
      next_second     = best;
      next_second_idx = best_idx;
    end else if (idx == FIRST_IDX || cand > second) begin
      next_second     = cand;
      next_second_idx = idx;
    end
  end

  assign next_margin = {next_best[WEIGHT_LENGTH-1], next_best}
                     - {next_second[WEIGHT_LENGTH-1], next_second};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      done_q     <= 1'b0;
      out_valid  <= 1'b0;
      pred_class <= '0;
      pred_score <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      best       <= '0;
      best_idx   <= '0;
      idx        <= '0;
      for (int i = 0; i < CLASS_NUM; i++) snap[i] <= '0;
`ifdef ARGMAX_RUNNER_UP_EN
      second       <= '0;
      second_idx   <= '0;
      runner_class <= '0;
      margin       <= '0;
`endif
    end else begin
      done_q <= adder_done;
      if (start && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < CLASS_NUM; i++) snap[i] <= class_sums[i];
            best     <= class_sums[0];
            best_idx <= '0;
            idx      <= FIRST_IDX;
            busy     <= 1'b1;
`ifdef ARGMAX_RUNNER_UP_EN
            second     <= class_sums[0];
            second_idx <= '0;
`endif
            if (CLASS_NUM == 1) begin
              state      <= RESULT;
              out_valid  <= 1'b1;
              pred_class <= '0;
              pred_score <= class_sums[0];
`ifdef ARGMAX_RUNNER_UP_EN
              runner_class <= '0;
              margin       <= '0;
`endif
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          best     <= next_best;
          best_idx <= next_best_idx;
          idx      <= idx + 1'b1;
`ifdef ARGMAX_RUNNER_UP_EN
          second     <= next_second;
          second_idx <= next_second_idx;
`endif
          if (idx == LAST_IDX) begin
            state      <= RESULT;
            out_valid  <= 1'b1;
            pred_class <= next_best_idx;
            pred_score <= next_best;
`ifdef ARGMAX_RUNNER_UP_EN
            runner_class <= next_second_idx;
            margin       <= next_margin;
`endif
          end
        end
        RESULT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_class_argmax_seq.sv
// Scoreboard bench for class_argmax_seq (CLASS_NUM=4, 12-bit sums); runner-up checks
// are compiled in when ARGMAX_RUNNER_UP_EN is defined.
module tb_class_argmax_seq;

  localparam int CN = 4;
  localparam int WL = 12;
  localparam int IW = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [CN-1:0][WL-1:0]    class_sums;
  logic                     adder_done;
  logic                     out_ready;
  logic                     out_valid;
  logic [IW-1:0]            pred_class;
  logic signed [WL-1:0]     pred_score;
  logic                     busy;
  logic                     overrun;
`ifdef ARGMAX_RUNNER_UP_EN
  logic [IW-1:0]            runner_class;
  logic [WL:0]              margin;
`endif

  class_argmax_seq #(.CLASS_NUM(CN), .WEIGHT_LENGTH(WL)) dut (
    .clk        (clk),
    .rst        (rst),
    .class_sums (class_sums),
    .adder_done (adder_done),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .pred_class (pred_class),
    .pred_score (pred_score),
    .busy       (busy),
    .overrun    (overrun)
`ifdef ARGMAX_RUNNER_UP_EN
    ,
    .runner_class (runner_class),
    .margin       (margin)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int cls;
    int score;
    int runner;
    int mrg;
    int startCyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart(input int hold);
    adder_done = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    adder_done = 1'b0;
  endtask

  // Called just after a clock edge; queues the hand-computed result, then pulses the start.
  task automatic applyStimulus(input int s0, input int s1, input int s2, input int s3,
                               input int cls, input int score, input int runner,
                               input int mrg, input int hold);
    exp_t e;
    class_sums[0] = WL'(s0);
    class_sums[1] = WL'(s1);
    class_sums[2] = WL'(s2);
    class_sums[3] = WL'(s3);
    e.cls = cls;
    e.score = score;
    e.runner = runner;
    e.mrg = mrg;
    e.startCyc = cyc;
    sb.push_back(e);
    pulseStart(hold);
  endtask

  task automatic waitDrain(input int bound);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("drain_in_time", (n < bound) ? 1 : 0, 1);
    nextCycle();
  endtask

  // Monitor: latency on every out_valid rise, payload on every handshake, drop afterwards.
  initial begin
    bit   prevValid;
    bit   hsPrev;
    exp_t e;
    prevValid = 1'b0;
    hsPrev    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevValid = 1'b0;
        hsPrev    = 1'b0;
      end else begin
        if (hsPrev) checkOutput("valid_drop", out_valid, 0);
        if (out_valid && !prevValid) begin
          if (sb.size() == 0) checkOutput("unexpected_result", 1, 0);
          else checkOutput("latency", cyc - sb[0].startCyc, CN);
        end
        hsPrev = 1'b0;
        if (out_valid && out_ready && sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("pred_class", pred_class, e.cls);
          checkOutput("pred_score", pred_score, e.score);
`ifdef ARGMAX_RUNNER_UP_EN
          checkOutput("runner_class", runner_class, e.runner);
          checkOutput("margin", margin, e.mrg);
`endif
          hsPrev = 1'b1;
        end
        prevValid = out_valid;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst        = 1'b1;
    adder_done = 1'b0;
    out_ready  = 1'b1;
    class_sums = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_pred_class", pred_class, 0);
    checkOutput("rst_pred_score", pred_score, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    nextCycle();

    $display("[TB] basic, ties, negative and extreme frames");
    applyStimulus(3, -7, 12, 5, 2, 12, 3, 7, 1);
    waitDrain(40);
    applyStimulus(9, 9, -1, 9, 0, 9, 1, 0, 1);
    waitDrain(40);
    applyStimulus(-5, -2, -8, -3, 1, -2, 3, 1, 1);
    waitDrain(40);
    applyStimulus(-2048, 2047, 0, 0, 1, 2047, 2, 2047, 1);
    waitDrain(40);
    applyStimulus(2047, -2048, -2048, -2048, 0, 2047, 1, 4095, 1);
    waitDrain(40);

    $display("[TB] backpressure with changing inputs");
    out_ready = 1'b0;
    applyStimulus(1, 2, 3, 4, 3, 4, 2, 1, 1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("bp_valid_in_time", (n < 20) ? 1 : 0, 1);
    repeat (6) begin
      nextCycle();
      class_sums = {WL'($urandom), WL'($urandom), WL'(2000), WL'($urandom)};
      @(negedge clk);
      checkOutput("bp_valid_held", out_valid, 1);
      checkOutput("bp_class_stable", pred_class, 3);
      checkOutput("bp_score_stable", pred_score, 4);
    end
    nextCycle();
    out_ready = 1'b1;
    waitDrain(40);

    $display("[TB] back-to-back at CLASS_NUM+1 spacing");
    applyStimulus(0, -1, -2, -3, 0, 0, 1, 1, 1);
    repeat (4) nextCycle();
    applyStimulus(-100, 50, 50, -2048, 1, 50, 2, 0, 1);
    waitDrain(40);
    checkOutput("no_overrun_b2b", overrun, 0);

    $display("[TB] overrun and level-held adder_done");
    applyStimulus(7, 100, -3, 99, 1, 100, 3, 1, 1);
    nextCycle();
    class_sums[0] = WL'(1000);
    pulseStart(1);
    waitDrain(40);
    checkOutput("overrun_set", overrun, 1);
    applyStimulus(-1, -1, -1, -1, 0, -1, 1, 0, 20);
    waitDrain(40);
    repeat (5) nextCycle();

    $display("[TB] async reset mid-scan");
    class_sums = {WL'(5), WL'(5), WL'(5), WL'(5)};
    pulseStart(1);
    @(posedge clk);
    #3;
    checkOutput("busy_in_scan", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_pred_class", pred_class, 0);
    checkOutput("abort_pred_score", pred_score, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    nextCycle();
    applyStimulus(10, 20, 30, 2047, 3, 2047, 2, 2017, 1);
    waitDrain(40);
    repeat (3) nextCycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
